// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder that stalls the pipeline per access
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] data_q;
    logic [31:0] mem_q [DEPTH];

    logic                  req;
    logic                  exec;
    logic                  illegal;
    logic [ADDR_WIDTH-1:0] idx;

    assign req  = MemRead_i | MemWrite_i;
    // The access happens on the edge that leaves the last BUSY cycle.
    assign exec = (state_q == BUSY) && (cnt_q == 4'd0);
    assign idx  = addr_q[ADDR_WIDTH+1:2];
    // Legality is judged on the captured request so BUSY-time input changes cannot alter it.
    assign illegal = (addr_q[1:0] != 2'b00)
                  || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0)
                  || (rd_q && wr_q);

    // State and latency counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic: IDLE -> BUSY (LATENCY cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs: stall is asserted combinationally on the accepting cycle, never during reset.
    always_comb begin
        stall_o = 1'b0;
        ack_o   = 1'b0;
        err_o   = 1'b0;
        if (!rst_i) begin
            stall_o = ((state_q == IDLE) && req) || (state_q == BUSY);
        end
        if (state_q == DONE) begin
            ack_o = 1'b1;
            err_o = illegal;
        end
    end

    // Request capture (IDLE only) and registered load data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            if ((state_q == IDLE) && req) begin
                addr_q  <= addr_i;
                wdata_q <= write_data_i;
                rd_q    <= MemRead_i;
                wr_q    <= MemWrite_i;
            end
            if (exec) begin
                if (illegal) begin
                    data_q <= 32'd0;
                end else if (rd_q) begin
                    data_q <= mem_q[idx];
                end
            end
        end
    end

    // Backing store write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && exec && wr_q && !illegal) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign data_o = data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;

    logic [31:0] data4, data1, data15;
    logic        stall4, ack4, err4;
    logic        stall1, ack1, err1;
    logic        stall15, ack15, err15;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .write_data_i(wdata),
        .MemRead_i(rd), .MemWrite_i(wr),
        .data_o(data4), .stall_o(stall4), .ack_o(ack4), .err_o(err4)
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .write_data_i(wdata),
        .MemRead_i(rd), .MemWrite_i(wr),
        .data_o(data1), .stall_o(stall1), .ack_o(ack1), .err_o(err1)
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) dut15 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .write_data_i(wdata),
        .MemRead_i(rd), .MemWrite_i(wr),
        .data_o(data15), .stall_o(stall15), .ack_o(ack15), .err_o(err15)
    );

    // Reference model: word array plus the last value data_o should show.
    logic [31:0] mem_m [1024];
    logic [31:0] dexp;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic e, output logic [31:0] q);
        e = (a % 4 != 0) || (a >= 32'h1000) || (r && w);
        if (e) dexp = 32'd0;
        else if (w) mem_m[a / 4] = d;
        else dexp = mem_m[a / 4];
        q = dexp;
    endtask

    // Issue one request on the 4-cycle DUT; report ack offset, stall count, err and data at DONE.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, output int off, output int stalls,
                          output logic e, output logic [31:0] q);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        off = -1; stalls = 0; e = 1'b0; q = 32'd0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (stall4) stalls++;
            if (ack4) begin
                off = c; e = err4; q = data4;
                break;
            end
            @(negedge clk);
            if (!hold) begin
                rd = 1'b0; wr = 1'b0;
            end
        end
    endtask

    task automatic run_checked(input string nm, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d, input bit hold,
                               input logic exp_e, input logic [31:0] exp_q);
        int off, stalls;
        logic e;
        logic [31:0] q;
        access(r, w, a, d, hold, off, stalls, e, q);
        chk({nm, " ack_offset"}, 32'(off), 32'd5);
        chk({nm, " stall_cycles"}, 32'(stalls), 32'd5);
        chk({nm, " err"}, {31'd0, e}, {31'd0, exp_e});
        chk({nm, " data"}, q, exp_q);
    endtask

    initial begin
        logic        me;
        logic [31:0] mq;
        int s1, s4, s15, a1, a4, a15, acks;

        tbl[0] = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 1'b1, 32'h13,   32'h1234,     1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
        tbl[4] = '{1'b0, 1'b1, 32'h20,   32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
        tbl[5] = '{1'b1, 1'b0, 32'h1000, 32'h0,        1'b1, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'h20,   32'h11111111, 1'b1, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'h20,   32'h0,        1'b0, 32'hCAFEF00D};

        // Reset with a request present: stall must stay low.
        rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h10; wdata = 32'h0;
        dexp = 32'd0;
        @(negedge clk); #1;
        chk("reset stall", {31'd0, stall4}, 32'd0);
        @(negedge clk);
        rst = 1'b0; rd = 1'b0;
        #1;
        chk("reset data_o", data4, 32'd0);
        chk("reset ack", {31'd0, ack4}, 32'd0);
        chk("reset err", {31'd0, err4}, 32'd0);
        chk("idle stall", {31'd0, stall4}, 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            model(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, me, mq);
            run_checked($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr,
                        tbl[i].wdata, 1'b0, tbl[i].err, tbl[i].data);
        end

        // Back-to-back stores with request held through DONE.
        for (int i = 0; i < 3; i++) begin
            model(1'b0, 1'b1, 32'h30 + 32'(i * 4), 32'h100 + 32'(i), me, mq);
            run_checked($sformatf("b2b%0d", i), 1'b0, 1'b1, 32'h30 + 32'(i * 4),
                        32'h100 + 32'(i), 1'b1, 1'b0, mq);
        end
        for (int i = 0; i < 3; i++) begin
            model(1'b1, 1'b0, 32'h30 + 32'(i * 4), 32'h0, me, mq);
            run_checked($sformatf("b2b_rd%0d", i), 1'b1, 1'b0, 32'h30 + 32'(i * 4),
                        32'h0, 1'b0, 1'b0, 32'h100 + 32'(i));
        end

        // Reset during BUSY discards the pending store.
        model(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, me, mq);
        run_checked("pre_store", 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 1'b0, mq);
        model(1'b1, 1'b0, 32'h40, 32'h0, me, mq);
        run_checked("pre_load", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5);
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = 32'h40; wdata = 32'h55;
        #1;
        chk("rstbusy accept stall", {31'd0, stall4}, 32'd1);
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstbusy stall in reset", {31'd0, stall4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dexp = 32'd0;
        #1;
        chk("rstbusy stall after", {31'd0, stall4}, 32'd0);
        chk("rstbusy ack after", {31'd0, ack4}, 32'd0);
        chk("rstbusy err after", {31'd0, err4}, 32'd0);
        chk("rstbusy data after", data4, 32'd0);
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (ack4) acks++;
        end
        chk("rstbusy no ack", 32'(acks), 32'd0);
        model(1'b1, 1'b0, 32'h40, 32'h0, me, mq);
        run_checked("post_rst_load", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5);

        // Latency sweep: the three instances accept the same one-cycle load.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rd = 1'b1; wr = 1'b0; addr = 32'h10;
        dexp = 32'd0;
        model(1'b1, 1'b0, 32'h10, 32'h0, me, mq);
        s1 = 0; s4 = 0; s15 = 0; a1 = 0; a4 = 0; a15 = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (stall1) s1++;
            if (stall4) s4++;
            if (stall15) s15++;
            if (ack1) a1++;
            if (ack4) a4++;
            if (ack15) a15++;
            @(negedge clk);
            rd = 1'b0;
        end
        chk("sweep L1 stalls", 32'(s1), 32'd2);
        chk("sweep L4 stalls", 32'(s4), 32'd5);
        chk("sweep L15 stalls", 32'(s15), 32'd16);
        chk("sweep L1 acks", 32'(a1), 32'd1);
        chk("sweep L4 acks", 32'(a4), 32'd1);
        chk("sweep L15 acks", 32'(a15), 32'd1);
        chk("sweep L4 data", data4, mq);

        // Randomized traffic against the model over a 16-word window.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b0, 1'b1, 32'h200 + 32'(i * 4), d, me, mq);
            run_checked($sformatf("rinit%0d", i), 1'b0, 1'b1, 32'h200 + 32'(i * 4), d,
                        1'b0, me, mq);
        end
        for (int i = 0; i < 80; i++) begin
            logic        r, w;
            logic [31:0] a, d;
            int          kind;
            kind = int'($urandom_range(0, 9));
            a = 32'h200 + 32'($urandom_range(0, 15) * 4);
            d = $urandom;
            r = $urandom_range(0, 1) == 1;
            w = !r;
            case (kind)
                0: a = a + 32'($urandom_range(1, 3));
                1: a = a | (32'h1 << $urandom_range(12, 31));
                2: begin r = 1'b1; w = 1'b1; end
                default: ;
            endcase
            model(r, w, a, d, me, mq);
            run_checked($sformatf("rand%0d", i), r, w, a, d, 1'b0, me, mq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
